uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte queue behind a UART receiver, first-word-fall-through.
// Ports: clk, rst (async, active high); i_rx_dv/i_rx_byte push one byte per
//   rising edge of i_rx_dv; o_data/o_valid/i_ready pop the head byte;
//   o_count/o_full/o_empty report occupancy; o_overflow is a sticky
//   dropped-byte flag cleared by i_clr_ovf.
//   Optional macro RX_FIFO_AF_EN adds the registered o_almost_full output
//   (count >= AF_LEVEL).
module uart_rx_fifo #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rx_dv,
   input  logic [7:0]        i_rx_byte,
   output logic [7:0]        o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ADDR_W:0]   o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow,
   input  logic              i_clr_ovf
`ifdef RX_FIFO_AF_EN
   ,
   output logic              o_almost_full
`endif
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              dv_prev_q;

   logic push, pop, wr_en, full, empty;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   always_comb begin
      push     = i_rx_dv & ~dv_prev_q;
      pop      = ~empty & i_ready;
      // a full queue still takes the byte if the head leaves this cycle
      wr_en    = push & (~full | pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
      // set dominates clear
      ovf_d = (push & full & ~pop) | (ovf_q & ~i_clr_ovf);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         // held high so a strobe already active at release is not a new edge
         dv_prev_q <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         dv_prev_q <= i_rx_dv;
      end
   end

   // storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= i_rx_byte;
   end

`ifdef RX_FIFO_AF_EN
   localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
   logic af_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) af_q <= 1'b0;
      else     af_q <= (count_d >= AF_C);
   end

   assign o_almost_full = af_q;
`endif

   assign o_valid    = ~empty;
   assign o_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign o_count    = count_q;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic       i_rx_dv;
   logic [7:0] i_rx_byte;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic [4:0] o_count;
   logic       o_full;
   logic       o_empty;
   logic       o_overflow;
   logic       i_clr_ovf;
`ifdef RX_FIFO_AF_EN
   logic       o_almost_full;
`endif

   int checks = 0;
   int errors = 0;

   uart_rx_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .i_rx_dv    (i_rx_dv),
      .i_rx_byte  (i_rx_byte),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_overflow (o_overflow),
      .i_clr_ovf  (i_clr_ovf)
`ifdef RX_FIFO_AF_EN
      ,
      .o_almost_full (o_almost_full)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
      step();
      i_rx_dv   = 1'b0;
      step();
   endtask

   initial begin
      rst       = 1'b1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      i_ready   = 1'b0;
      i_clr_ovf = 1'b0;
      #1;
      chk("rst_count", o_count, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_empty", o_empty, 1);
      chk("rst_full", o_full, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_data", o_data, 8'h00);
      step();
      step();
      rst = 1'b0;
      step();

      // two-cycle strobe stores one byte
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'h5A;
      chk("pre_valid", o_valid, 0);
      step();
      chk("strb_count", o_count, 1);
      chk("strb_valid", o_valid, 1);
      chk("strb_data", o_data, 8'h5A);
      step();
      chk("strb_hold_count", o_count, 1);
      i_rx_dv = 1'b0;
      step();
      chk("strb_once_count", o_count, 1);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk("strb_pop_empty", o_empty, 1);
      chk("strb_pop_data", o_data, 8'h00);

      // push to empty with ready high must not pop
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'h77;
      i_ready   = 1'b1;
      step();
      chk("emp_push_count", o_count, 1);
      chk("emp_push_data", o_data, 8'h77);
      step();
      chk("emp_push_drain", o_count, 0);
      i_rx_dv = 1'b0;
      i_ready = 1'b0;
      step();

      // fill then drain in order
      for (int i = 1; i <= 16; i++) push_byte(8'(i));
      chk("fill_full", o_full, 1);
      chk("fill_count", o_count, 16);
      i_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("drain_%0d", i), o_data, 32'(i));
         step();
      end
      i_ready = 1'b0;
      chk("drain_empty", o_empty, 1);
      chk("drain_count", o_count, 0);

      // overflow on a full queue
      for (int i = 1; i <= 16; i++) push_byte(8'(i));
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'hAA;
      step();
      chk("ovf_set", o_overflow, 1);
      chk("ovf_count", o_count, 16);
      chk("ovf_head", o_data, 8'h01);
      i_rx_dv = 1'b0;
      step();
      chk("ovf_sticky", o_overflow, 1);
      i_clr_ovf = 1'b1;
      step();
      i_clr_ovf = 1'b0;
      chk("ovf_clr", o_overflow, 0);
      // drop together with a clear: set wins
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'hCC;
      i_clr_ovf = 1'b1;
      step();
      i_rx_dv   = 1'b0;
      i_clr_ovf = 1'b0;
      chk("ovf_set_wins", o_overflow, 1);
      step();
      i_clr_ovf = 1'b1;
      step();
      i_clr_ovf = 1'b0;
      chk("ovf_clr2", o_overflow, 0);

      // full queue, push and pop together
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'hBB;
      i_ready   = 1'b1;
      step();
      i_rx_dv = 1'b0;
      i_ready = 1'b0;
      chk("fpp_count", o_count, 16);
      chk("fpp_head", o_data, 8'h02);
      step();
      i_ready = 1'b1;
      for (int i = 2; i <= 16; i++) begin
         chk($sformatf("fpp_rd_%0d", i), o_data, 32'(i));
         step();
      end
      chk("fpp_rd_bb", o_data, 8'hBB);
      step();
      i_ready = 1'b0;
      chk("fpp_empty", o_empty, 1);

      // strobe held through reset release
      rst     = 1'b1;
      i_rx_dv = 1'b1;
      i_rx_byte = 8'h99;
      step();
      rst = 1'b0;
      step();
      step();
      chk("rel_hold_count", o_count, 0);
      i_rx_dv = 1'b0;
      step();

      // push and pop on a non-empty queue
      push_byte(8'h11);
      push_byte(8'h22);
      i_rx_dv   = 1'b1;
      i_rx_byte = 8'h33;
      i_ready   = 1'b1;
      step();
      i_rx_dv = 1'b0;
      i_ready = 1'b0;
      chk("pp_count", o_count, 2);
      chk("pp_head", o_data, 8'h22);
      i_ready = 1'b1;
      step();
      chk("pp_next", o_data, 8'h33);
      step();
      i_ready = 1'b0;
      chk("pp_empty", o_empty, 1);

      // reset mid-operation acts without a clock edge
      for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
      chk("mid_count5", o_count, 5);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_count", o_count, 0);
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_data", o_data, 8'h00);
      step();
      rst = 1'b0;
      step();

`ifdef RX_FIFO_AF_EN
      chk("af_reset", o_almost_full, 0);
      for (int i = 0; i < 11; i++) push_byte(8'(i));
      chk("af_11", o_almost_full, 0);
      push_byte(8'h0B);
      chk("af_12", o_almost_full, 1);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk("af_pop", o_almost_full, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
